// File: rtl/hs_rx_pkg.sv
// Shared types and constants for the HS receive controller.
// Optional hunt timeout is enabled with `define HS_RX_SYNC_TIMEOUT_EN.
package hs_rx_pkg;

  localparam int CNT_W = 8;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SETTLE    = 3'd1;
  localparam logic [2:0] ST_HUNT      = 3'd2;
  localparam logic [2:0] ST_RECEIVE   = 3'd3;
  localparam logic [2:0] ST_WAIT_EXIT = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    SETTLE    = ST_SETTLE,
    HUNT      = ST_HUNT,
    RECEIVE   = ST_RECEIVE,
    WAIT_EXIT = ST_WAIT_EXIT
  } state_t;

endpackage

// File: rtl/hs_byte_aligner.sv
// Selects an aligned byte from the two-byte window {cur, prev}.
// Offsets above 8 saturate to 8, which passes cur through unshifted.
module hs_byte_aligner (
  input  logic [7:0] cur,
  input  logic [7:0] prev,
  input  logic [3:0] offset,
  output logic [7:0] aligned
);

  logic [15:0] window;
  logic [3:0]  shift;

  assign window  = {cur, prev};
  assign shift   = (offset > 4'd8) ? 4'd8 : offset;
  assign aligned = window[shift +: 8];

endmodule

// File: rtl/hs_rx_controller.sv
// HS receive controller: settle, sync hunt, byte alignment, exit handling.
// Define HS_RX_SYNC_TIMEOUT_EN to build the hunt timeout and error pulse.
module hs_rx_controller
  import hs_rx_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int SYNC_TIMEOUT  = 32
) (
  input  logic       RxByteClkHS,
  input  logic       Rst,
  input  logic       HsEntry,
  input  logic       HsExit,
  input  logic [7:0] DataHS,
  input  logic       RxSyncHS,
  input  logic [3:0] RxSyncPosition,
  output logic       SyncEnable,
  output logic       RxActiveHS,
  output logic       RxValidHS,
  output logic [7:0] RxDataHS,
  output logic       RxErrSotSyncHS
);

  localparam logic [CNT_W-1:0] SETTLE_LAST =
    CNT_W'(SETTLE_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] settle_cnt;
  logic [3:0]       offset;
  logic [7:0]       prev;
  logic             filled;
  logic [7:0]       aligned;

`ifdef HS_RX_SYNC_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HUNT_LAST =
    CNT_W'(SYNC_TIMEOUT - 1);
  logic [CNT_W-1:0] hunt_cnt;
`else
  assign RxErrSotSyncHS = 1'b0;
`endif

  hs_byte_aligner u_align (
    .cur     (DataHS),
    .prev    (prev),
    .offset  (offset),
    .aligned (aligned)
  );

  always_ff @(posedge RxByteClkHS or posedge Rst) begin
    if (Rst) begin
      state      <= IDLE;
      settle_cnt <= '0;
      offset     <= 4'd0;
      prev       <= 8'h00;
      filled     <= 1'b0;
      SyncEnable <= 1'b0;
      RxActiveHS <= 1'b0;
      RxValidHS  <= 1'b0;
      RxDataHS   <= 8'h00;
`ifdef HS_RX_SYNC_TIMEOUT_EN
      hunt_cnt       <= '0;
      RxErrSotSyncHS <= 1'b0;
`endif
    end else begin
      prev       <= DataHS;
      settle_cnt <= '0;
`ifdef HS_RX_SYNC_TIMEOUT_EN
      hunt_cnt       <= '0;
      RxErrSotSyncHS <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (HsEntry) begin
            if (SETTLE_CYCLES == 0) begin
              state      <= HUNT;
              SyncEnable <= 1'b1;
            end else begin
              state <= SETTLE;
            end
          end
        end
        SETTLE: begin
          if (HsExit) begin
            state <= IDLE;
          end else if (settle_cnt == SETTLE_LAST) begin
            state      <= HUNT;
            SyncEnable <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        HUNT: begin
          if (HsExit) begin
            state      <= IDLE;
            SyncEnable <= 1'b0;
          end else if (RxSyncHS) begin
            // sync beats a coincident timeout
            state      <= RECEIVE;
            offset     <= RxSyncPosition;
            SyncEnable <= 1'b0;
            RxActiveHS <= 1'b1;
            filled     <= 1'b0;
          end else begin
`ifdef HS_RX_SYNC_TIMEOUT_EN
            if (hunt_cnt == HUNT_LAST) begin
              state          <= WAIT_EXIT;
              SyncEnable     <= 1'b0;
              RxErrSotSyncHS <= 1'b1;
            end else begin
              hunt_cnt <= hunt_cnt + 1'b1;
            end
`endif
          end
        end
        RECEIVE: begin
          if (HsExit) begin
            state      <= IDLE;
            RxActiveHS <= 1'b0;
            RxValidHS  <= 1'b0;
            filled     <= 1'b0;
          end else begin
            // first cycle only primes prev
            RxDataHS  <= aligned;
            filled    <= 1'b1;
            RxValidHS <= filled;
          end
        end
        WAIT_EXIT: begin
          if (HsExit) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hs_rx_controller.sv
// Scoreboard bench for hs_rx_controller with a byte-level reference model.
// Timeout checks adapt to whether HS_RX_SYNC_TIMEOUT_EN is defined.
module tb_hs_rx_controller;

  logic       RxByteClkHS = 1'b0;
  logic       Rst;
  logic       HsEntry;
  logic       HsExit;
  logic [7:0] DataHS;
  logic       RxSyncHS;
  logic [3:0] RxSyncPosition;
  logic       SyncEnable;
  logic       RxActiveHS;
  logic       RxValidHS;
  logic [7:0] RxDataHS;
  logic       RxErrSotSyncHS;

  int n_cmp = 0;
  int n_bad = 0;
  int err_pulses = 0;
  logic [7:0] last_rx = 8'h00;
  logic [7:0] exp_q[$];
  logic [7:0] stim[$];

  hs_rx_controller #(.SETTLE_CYCLES(4), .SYNC_TIMEOUT(32)) dut (
    .RxByteClkHS    (RxByteClkHS),
    .Rst            (Rst),
    .HsEntry        (HsEntry),
    .HsExit         (HsExit),
    .DataHS         (DataHS),
    .RxSyncHS       (RxSyncHS),
    .RxSyncPosition (RxSyncPosition),
    .SyncEnable     (SyncEnable),
    .RxActiveHS     (RxActiveHS),
    .RxValidHS      (RxValidHS),
    .RxDataHS       (RxDataHS),
    .RxErrSotSyncHS (RxErrSotSyncHS)
  );

  always #5 RxByteClkHS = ~RxByteClkHS;

  // Aligned byte = bits [pos+7:pos] of cur*256+prev, pos capped at 8
  function automatic logic [7:0] ref_byte(input logic [7:0] cur,
                                          input logic [7:0] prv,
                                          input int pos);
    int sh;
    int w;
    sh = (pos > 8) ? 8 : pos;
    w  = int'(cur) * 256 + int'(prv);
    return 8'((w / (1 << sh)) % 256);
  endfunction

  task automatic tick();
    @(posedge RxByteClkHS);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge RxByteClkHS) begin
    if (RxErrSotSyncHS === 1'b1) err_pulses++;
    if (RxValidHS === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_extra: RxDataHS=%0h with nothing expected",
                 RxDataHS);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (RxDataHS !== e) begin
          n_bad++;
          $display("FAIL sb_byte: got %0h expected %0h", RxDataHS, e);
        end
        last_rx = RxDataHS;
      end
    end
  end

  task automatic enter_hunt();
    HsEntry = 1'b1;
    tick();
    HsEntry = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check("settle_se_low", SyncEnable, 1'b0);
      tick();
    end
    check("hunt_se_high", SyncEnable, 1'b1);
  endtask

  // Hunt w extra cycles, sync at pos, stream stim[], then HsExit
  task automatic run_rx(input int w, input int pos);
    enter_hunt();
    repeat (w) begin
      DataHS = 8'($urandom);
      tick();
    end
    check("still_hunting", SyncEnable, 1'b1);
    RxSyncHS       = 1'b1;
    RxSyncPosition = 4'(pos);
    DataHS         = 8'($urandom);
    tick();
    check("rx_active", RxActiveHS, 1'b1);
    check("rx_se_low", SyncEnable, 1'b0);
    for (int k = 0; k < stim.size(); k++) begin
      DataHS         = stim[k];
      RxSyncHS       = 1'($urandom);
      RxSyncPosition = 4'($urandom);
      HsEntry        = 1'($urandom);
      if (k > 0) exp_q.push_back(ref_byte(stim[k], stim[k-1], pos));
      tick();
    end
    RxSyncHS = 1'b0;
    HsEntry  = 1'b0;
    HsExit   = 1'b1;
    tick();
    HsExit = 1'b0;
    check("exit_active_low", RxActiveHS, 1'b0);
    check("exit_valid_low", RxValidHS, 1'b0);
    tick();
    check("sb_drain", exp_q.size(), 0);
  endtask

  initial begin
    int base;
    Rst = 1'b1;
    HsEntry = 1'b0;
    HsExit = 1'b0;
    DataHS = 8'h00;
    RxSyncHS = 1'b0;
    RxSyncPosition = 4'd0;
    repeat (2) tick();
    check("rst_se", SyncEnable, 1'b0);
    check("rst_active", RxActiveHS, 1'b0);
    check("rst_valid", RxValidHS, 1'b0);
    check("rst_data", RxDataHS, 8'h00);
    check("rst_err", RxErrSotSyncHS, 1'b0);
    Rst = 1'b0;
    tick();

    // IDLE ignores everything but HsEntry
    repeat (10) begin
      RxSyncHS = 1'($urandom);
      HsExit   = 1'($urandom);
      DataHS   = 8'($urandom);
      tick();
      check("idle_se", SyncEnable, 1'b0);
      check("idle_active", RxActiveHS, 1'b0);
    end
    RxSyncHS = 1'b0;
    HsExit   = 1'b0;

    stim = '{8'hA5, 8'h3C};
    run_rx(3, 3);
    check("pos3_byte", last_rx, 8'h94);

    stim = '{8'($urandom), 8'h5A};
    run_rx(0, 8);
    check("pos8_byte", last_rx, 8'h5A);

    // sync on the last permitted hunt cycle
    base = err_pulses;
    stim = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
`ifdef HS_RX_SYNC_TIMEOUT_EN
    run_rx(31, int'($urandom_range(0, 15)));
`else
    run_rx(45, int'($urandom_range(0, 15)));
`endif
    check("sync_wins_no_err", err_pulses, base);

`ifdef HS_RX_SYNC_TIMEOUT_EN
    enter_hunt();
    repeat (31) tick();
    check("pre_timeout_se", SyncEnable, 1'b1);
    check("pre_timeout_err", RxErrSotSyncHS, 1'b0);
    tick();
    check("timeout_err", RxErrSotSyncHS, 1'b1);
    tick();
    check("timeout_err_drop", RxErrSotSyncHS, 1'b0);
    check("wait_exit_se", SyncEnable, 1'b0);
    HsEntry = 1'b1;
    tick();
    HsEntry = 1'b0;
    repeat (6) tick();
    check("wait_exit_ignore", SyncEnable, 1'b0);
    HsExit = 1'b1;
    tick();
    HsExit = 1'b0;
    check("timeout_one_pulse", err_pulses, base + 1);
`else
    enter_hunt();
    repeat (40) tick();
    check("no_timeout_se", SyncEnable, 1'b1);
    check("no_timeout_err", err_pulses, base);
    HsExit = 1'b1;
    tick();
    HsExit = 1'b0;
    check("hunt_exit_se", SyncEnable, 1'b0);
`endif

    // HsExit during SETTLE aborts quietly
    HsEntry = 1'b1;
    tick();
    HsEntry = 1'b0;
    repeat (2) tick();
    HsExit = 1'b1;
    tick();
    HsExit = 1'b0;
    repeat (6) tick();
    check("settle_exit_se", SyncEnable, 1'b0);

    // HsExit during HUNT aborts with no later error
    base = err_pulses;
    enter_hunt();
    repeat (3) tick();
    HsExit = 1'b1;
    tick();
    HsExit = 1'b0;
    check("hunt_exit_se2", SyncEnable, 1'b0);
    repeat (40) tick();
    check("hunt_exit_no_err", err_pulses, base);
    check("hunt_exit_idle", SyncEnable, 1'b0);

    // asynchronous reset in the middle of RECEIVE
    enter_hunt();
    RxSyncHS       = 1'b1;
    RxSyncPosition = 4'd5;
    tick();
    RxSyncHS = 1'b0;
    stim = '{8'($urandom), 8'($urandom), 8'($urandom)};
    for (int k = 0; k < 3; k++) begin
      DataHS = stim[k];
      if (k > 0) exp_q.push_back(ref_byte(stim[k], stim[k-1], 5));
      tick();
    end
    check("pre_rst_valid", RxValidHS, 1'b1);
    #1 Rst = 1'b1;
    #1;
    check("async_rst_active", RxActiveHS, 1'b0);
    check("async_rst_valid", RxValidHS, 1'b0);
    check("async_rst_data", RxDataHS, 8'h00);
    exp_q.delete();
    tick();
    Rst = 1'b0;
    tick();

    repeat (12) begin
      int n;
      n = int'($urandom_range(2, 8));
      stim.delete();
      repeat (n) stim.push_back(8'($urandom));
`ifdef HS_RX_SYNC_TIMEOUT_EN
      run_rx(int'($urandom_range(0, 31)), int'($urandom_range(0, 15)));
`else
      run_rx(int'($urandom_range(0, 40)), int'($urandom_range(0, 15)));
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
